rob_complete_arbiter: RTL and testbench

Shares the reorder buffer's single completion port (complete / rob_number / data / changeFlow) between NUM_REQ functional-unit writeback requesters (ALU, multiplier, load/store, branch).
- Each requester has a one-entry holding register.
- A round-robin scheduler issues at most one completion per cycle through a registered output stage.
- The ROB flush signal (changeFlow_out) discards all pending completions.
- Sits between the execution units and reorder_buffer in OoOPipe.

---
 rtl/rob_complete_arbiter_pkg.sv | 20 ++
 rtl/rob_complete_arbiter_rr_arbiter.sv | 32 +++
 rtl/rob_complete_arbiter.sv | 106 ++++++++++
 tb/tb_rob_complete_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_complete_arbiter_pkg.sv
// Shared completion-port definitions used by reorder_buffer and rob_complete_arbiter:
// ROB geometry, completion record layout and a wrap-around increment helper.
package rob_complete_arbiter_pkg;

  localparam int ROB_DEPTH     = 16;
  localparam int ROB_IDX_BITS  = $clog2(ROB_DEPTH);
  localparam int CPL_DATA_BITS = 32;

  typedef struct packed {
    logic [ROB_IDX_BITS-1:0]  rob;
    logic [CPL_DATA_BITS-1:0] data;
    logic                     cf;
  } completion_t;

  // Explicit compare so a non-power-of-2 modulus wraps correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rob_complete_arbiter_rr_arbiter.sv
// Generic round-robin selector: first set request at or after ptr (mod N),
// returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int pos;
    // NOTE: every output gets a default before the search loop, otherwise
    // the paths that never hit a request would infer latches.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!valid && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_complete_arbiter.sv
// Funnels NUM_REQ functional-unit writebacks into the ROB's single completion
// port: one-entry holder per requester, round-robin pick, registered output.
module rob_complete_arbiter
  import rob_complete_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = ROB_IDX_BITS,
  parameter int DATA_W    = CPL_DATA_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_num,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_changeFlow,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         complete,
  output logic [ROB_IDX_W-1:0]         rob_number,
  output logic [DATA_W-1:0]            data,
  output logic                         changeFlow,
  output logic                         busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   hold_valid;
  logic [ROB_IDX_W-1:0] hold_rob  [NUM_REQ];
  logic [DATA_W-1:0]    hold_data [NUM_REQ];
  logic [NUM_REQ-1:0]   hold_cf;

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [NUM_REQ-1:0]   capture;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr_arbiter (
    .req   (hold_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  // A holder being drained this cycle may be refilled in the same cycle.
  assign req_ready = {NUM_REQ{~flush}} & (~hold_valid | grant);
  assign capture   = req_valid & req_ready;
  assign busy      = |hold_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= '0;
    end else if (flush) begin
      hold_valid <= '0;
    end else begin
      hold_valid <= (hold_valid & ~grant) | capture;
    end
  end

  // NOTE: holder payloads carry no reset; hold_valid alone qualifies them,
  // so they can map to plain enable flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (capture[i]) begin
        hold_rob[i]  <= req_rob_num[i*ROB_IDX_W +: ROB_IDX_W];
        hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        hold_cf[i]   <= req_changeFlow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (!flush && grant_valid) begin
      rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx), NUM_REQ));
    end
  end

  // Payload holds its last value when idle; the ROB only looks at it with complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      complete   <= 1'b0;
      rob_number <= '0;
      data       <= '0;
      changeFlow <= 1'b0;
    end else if (flush) begin
      complete   <= 1'b0;
      changeFlow <= 1'b0;
    end else begin
      complete <= grant_valid;
      if (grant_valid) begin
        rob_number <= hold_rob[grant_idx];
        data       <= hold_data[grant_idx];
        changeFlow <= hold_cf[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed bench for rob_complete_arbiter: expected completions are queued as
// requests are driven and compared in order whenever complete is seen.
module tb_rob_complete_arbiter;
  import rob_complete_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int RW = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*RW-1:0] req_rob_num;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_changeFlow;
  logic [N-1:0]    req_ready;
  logic            complete;
  logic [RW-1:0]   rob_number;
  logic [DW-1:0]   data;
  logic            changeFlow;
  logic            busy;

  completion_t exp_q[$];
  completion_t mon_e;
  int n_checks = 0;
  int n_pass   = 0;

  rob_complete_arbiter #(
    .NUM_REQ   (N),
    .ROB_IDX_W (RW),
    .DATA_W    (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_rob_num    (req_rob_num),
    .req_data       (req_data),
    .req_changeFlow (req_changeFlow),
    .req_ready      (req_ready),
    .complete       (complete),
    .rob_number     (rob_number),
    .data           (data),
    .changeFlow     (changeFlow),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [RW-1:0] rob,
                           input logic [DW-1:0] d, input logic cf, input bit expect_cpl);
    completion_t e;
    req_valid[i]            = 1'b1;
    req_rob_num[i*RW +: RW] = rob;
    req_data[i*DW +: DW]    = d;
    req_changeFlow[i]       = cf;
    if (expect_cpl) begin
      e.rob  = rob;
      e.data = d;
      e.cf   = cf;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_reqs();
    req_valid      = '0;
    req_changeFlow = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Scoreboard: each cycle complete is high consumes one queued expectation.
  always @(negedge clk) begin
    if (rst && complete) begin
      if (exp_q.size() == 0) begin
        check("cpl_unexpected", 64'(complete), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("cpl_rob", 64'(rob_number), 64'(mon_e.rob));
        check("cpl_data", 64'(data), 64'(mon_e.data));
        check("cpl_cf", 64'(changeFlow), 64'(mon_e.cf));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    req_valid      = '0;
    req_rob_num    = '0;
    req_data       = '0;
    req_changeFlow = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_complete", 64'(complete), 64'd0);
    check("rst_rob", 64'(rob_number), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_cf", 64'(changeFlow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'hF);

    // Single request, two-edge latency, one-cycle pulse.
    drive_req(1, 4'h3, 32'h0000_0005, 1'b0, 1'b1);
    tick();
    clear_reqs();
    check("single_busy", 64'(busy), 64'd1);
    check("single_early", 64'(complete), 64'd0);
    tick();
    check("single_cpl", 64'(complete), 64'd1);
    check("single_rob", 64'(rob_number), 64'd3);
    check("single_busy_clr", 64'(busy), 64'd0);
    tick();
    check("single_pulse", 64'(complete), 64'd0);

    // All four at once from a fresh pointer: grants 0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, RW'(i), DW'(32'h100 + i), 1'b0, 1'b1);
    tick();
    clear_reqs();
    check("sim_ready0", 64'(req_ready), 64'h1);
    tick();
    check("sim_cpl0", 64'(complete), 64'd1);
    check("sim_ready1", 64'(req_ready), 64'h3);
    tick();
    check("sim_cpl1", 64'(complete), 64'd1);
    check("sim_ready2", 64'(req_ready), 64'h7);
    tick();
    check("sim_cpl2", 64'(complete), 64'd1);
    check("sim_ready3", 64'(req_ready), 64'hF);
    tick();
    check("sim_cpl3", 64'(complete), 64'd1);
    tick();
    check("sim_idle", 64'(complete), 64'd0);

    // Rotation: after a grant to 2, a full reload goes 3,0,1,2.
    do_reset();
    drive_req(2, 4'h2, 32'h200, 1'b0, 1'b1);
    tick();
    clear_reqs();
    tick();
    drive_req(3, 4'hB, 32'h303, 1'b0, 1'b1);
    drive_req(0, 4'h8, 32'h300, 1'b0, 1'b1);
    drive_req(1, 4'h9, 32'h301, 1'b0, 1'b1);
    drive_req(2, 4'hA, 32'h302, 1'b0, 1'b1);
    tick();
    clear_reqs();
    repeat (5) tick();
    check("rot_idle", 64'(complete), 64'd0);

    // Streaming from requester 0 through the grant-refill path.
    for (int i = 0; i < 16; i++) begin
      drive_req(0, RW'(i), DW'(i * 3 + 1), 1'b0, 1'b1);
      check("stream_ready", 64'(req_ready[0]), 64'd1);
      tick();
      if (i >= 1) check("stream_cpl", 64'(complete), 64'd1);
    end
    clear_reqs();
    tick();
    check("stream_last", 64'(complete), 64'd1);
    tick();
    check("stream_idle", 64'(complete), 64'd0);

    // Flush drops holders 0,2,3 before they are presented.
    drive_req(0, 4'h5, 32'h55, 1'b0, 1'b0);
    drive_req(2, 4'h6, 32'h66, 1'b0, 1'b0);
    drive_req(3, 4'h7, 32'h77, 1'b1, 1'b0);
    tick();
    clear_reqs();
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'h0);
    tick();
    flush = 1'b0;
    check("flush_cpl", 64'(complete), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_cf", 64'(changeFlow), 64'd0);
    repeat (4) tick();
    check("flush_quiet", 64'(complete), 64'd0);
    drive_req(2, 4'h9, 32'h99, 1'b0, 1'b1);
    tick();
    clear_reqs();
    tick();
    check("post_flush_cpl", 64'(complete), 64'd1);
    check("post_flush_rob", 64'(rob_number), 64'd9);

    // Redirect completion carries changeFlow and target address.
    drive_req(3, 4'hA, 32'h0000_0040, 1'b1, 1'b1);
    tick();
    clear_reqs();
    tick();
    check("redir_cf", 64'(changeFlow), 64'd1);
    check("redir_data", 64'(data), 64'h40);
    tick();
    check("redir_idle", 64'(complete), 64'd0);

    // Asynchronous reset mid-burst with three holders pending.
    drive_req(0, 4'h1, 32'h11, 1'b0, 1'b0);
    drive_req(1, 4'h2, 32'h22, 1'b1, 1'b0);
    drive_req(2, 4'h3, 32'h33, 1'b0, 1'b0);
    tick();
    clear_reqs();
    tick();
    #1 rst = 1'b0;
    #1;
    check("arst_complete", 64'(complete), 64'd0);
    check("arst_rob", 64'(rob_number), 64'd0);
    check("arst_data", 64'(data), 64'd0);
    check("arst_cf", 64'(changeFlow), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("arst_ready", 64'(req_ready), 64'hF);
    repeat (6) begin
      tick();
      check("arst_quiet", 64'(complete), 64'd0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
